prga_decrypt: RTL and testbench

PRGA_DECRYPT -- requirements
Module: prga_decrypt

---
 rtl/prga_decrypt_if.sv | 27 ++
 rtl/prga_decrypt.sv | 120 ++++++++++++
 tb/tb_prga_decrypt.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prga_decrypt_if.sv
// Memory-side bus of the RC4 PRGA decrypter: S-memory, encrypted-message ROM
// and decrypted-message RAM ports.
interface prga_decrypt_if #(
    parameter int unsigned MSG_LENGTH = 32
);
    localparam int unsigned AW = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1;

    logic [7:0]    s_address;
    logic [7:0]    s_data;
    logic          s_wren;
    logic [7:0]    s_q;
    logic [AW-1:0] rom_address;
    logic [7:0]    rom_q;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_wren;

    modport master (
        output s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren,
        input  s_q, rom_q
    );

    modport slave (
        input  s_address, s_data, s_wren, rom_address, ram_address, ram_data, ram_wren,
        output s_q, rom_q
    );
endinterface

// File: rtl/prga_decrypt.sv
// RC4 pseudo-random generation stage: walks the already shuffled S memory,
// XORs the keystream with the encrypted ROM and writes the plaintext to RAM.
// Memories have two-edge read latency, so every read is RD -> WT -> CP.
module prga_decrypt #(
    parameter int unsigned MSG_LENGTH = 32
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    prga_decrypt_if.master mem
);
    localparam int unsigned AW     = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1;
    localparam logic [7:0]  K_LAST = 8'(MSG_LENGTH - 1);

    typedef enum logic [3:0] {
        IDLE, RD_SI, WT_SI, CP_SI, RD_SJ, WT_SJ, CP_SJ, WR_SI, WR_SJ,
        RD_F, WT_F, CP_F, WR_RAM, NEXT, DONE
    } state_t;

    state_t     state_q;
    logic [7:0] i_q, j_q, k_q, si_q, sj_q, f_q;
    logic [7:0] j_d;

    // j advances by S[i] as soon as S[i] arrives; the same sum addresses S[j]
    assign j_d = j_q + mem.s_q;

    // plaintext byte is held in f and presented straight from that register
    assign mem.ram_data = f_q;

    // sequencer: one state per cycle, outputs registered for the state being entered
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            i_q             <= '0;
            j_q             <= '0;
            k_q             <= '0;
            si_q            <= '0;
            sj_q            <= '0;
            f_q             <= '0;
            done            <= 1'b0;
            mem.s_address   <= '0;
            mem.s_data      <= '0;
            mem.s_wren      <= 1'b0;
            mem.rom_address <= '0;
            mem.ram_address <= '0;
            mem.ram_wren    <= 1'b0;
        end else begin
            mem.s_wren   <= 1'b0;
            mem.ram_wren <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q           <= 8'd1;
                        j_q           <= '0;
                        k_q           <= '0;
                        mem.s_address <= 8'd1;
                        state_q       <= RD_SI;
                    end
                end
                RD_SI: state_q <= WT_SI;
                WT_SI: state_q <= CP_SI;
                CP_SI: begin
                    si_q          <= mem.s_q;
                    j_q           <= j_d;
                    mem.s_address <= j_d;
                    state_q       <= RD_SJ;
                end
                RD_SJ: state_q <= WT_SJ;
                WT_SJ: state_q <= CP_SJ;
                CP_SJ: begin
                    sj_q          <= mem.s_q;
                    mem.s_address <= i_q;
                    mem.s_data    <= mem.s_q;
                    mem.s_wren    <= 1'b1;
                    state_q       <= WR_SI;
                end
                WR_SI: begin
                    mem.s_address <= j_q;
                    mem.s_data    <= si_q;
                    mem.s_wren    <= 1'b1;
                    state_q       <= WR_SJ;
                end
                WR_SJ: begin
                    // pre-swap values; their sum equals S[i]+S[j] after the swap
                    mem.s_address   <= si_q + sj_q;
                    mem.rom_address <= AW'(k_q);
                    state_q         <= RD_F;
                end
                RD_F: state_q <= WT_F;
                WT_F: state_q <= CP_F;
                CP_F: begin
                    f_q             <= mem.s_q ^ mem.rom_q;
                    mem.ram_address <= AW'(k_q);
                    mem.ram_wren    <= 1'b1;
                    state_q         <= WR_RAM;
                end
                WR_RAM: state_q <= NEXT;
                NEXT: begin
                    if (k_q == K_LAST) begin
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q           <= k_q + 8'd1;
                        i_q           <= i_q + 8'd1;
                        mem.s_address <= i_q + 8'd1;
                        state_q       <= RD_SI;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: behavioural S/ROM/RAM memories with two-edge read
// latency, and a plain RC4 keystream model computed over the bench's own arrays.
module tb_prga_decrypt;
    localparam int unsigned ML = 32;
    localparam int unsigned AW = 5;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b0;
    logic start    = 1'b0;
    logic done;

    prga_decrypt_if #(.MSG_LENGTH(ML)) bus ();

    prga_decrypt #(.MSG_LENGTH(ML)) u_dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .done     (done),
        .mem      (bus.master)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // memory contents and logs
    logic [7:0] s_init  [256];
    logic [7:0] smem    [256];
    logic [7:0] rom_mem [ML];
    logic [7:0] ram_mem [ML];
    logic       load = 1'b0;
    logic [7:0] s_addr_r;
    logic [AW-1:0] rom_addr_r;
    int         cyc = 0;
    int         ram_cnt = 0;
    int         ram_cyc [64];
    int         ram_alog[64];
    int         sw_cnt = 0;
    int         sw_a [128];
    int         sw_d [128];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         e0;
    int         model_s [256];
    int         model_f [ML];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // S memory and ROM with registered address and registered data
    always @(posedge CLOCK_50) begin
        if (load) begin
            for (int n = 0; n < 256; n++) smem[n] <= s_init[n];
        end else if (bus.s_wren) begin
            smem[bus.s_address] <= bus.s_data;
        end
        s_addr_r   <= bus.s_address;
        bus.s_q    <= smem[s_addr_r];
        rom_addr_r <= bus.rom_address;
        bus.rom_q  <= rom_mem[rom_addr_r];
    end

    // RAM capture and write logs
    always @(posedge CLOCK_50) begin
        if (load) begin
            ram_cnt <= 0;
            sw_cnt  <= 0;
        end else begin
            if (bus.ram_wren) begin
                ram_mem[bus.ram_address] <= bus.ram_data;
                if (ram_cnt < 64) begin
                    ram_cyc[ram_cnt]  <= cyc;
                    ram_alog[ram_cnt] <= int'(bus.ram_address);
                end
                ram_cnt <= ram_cnt + 1;
            end
            if (bus.s_wren) begin
                if (sw_cnt < 128) begin
                    sw_a[sw_cnt] <= int'(bus.s_address);
                    sw_d[sw_cnt] <= int'(bus.s_data);
                end
                sw_cnt <= sw_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // plain RC4 PRGA over the loaded S image and ROM
    task automatic ref_prga();
        int i, j, t;
        for (int n = 0; n < 256; n++) model_s[n] = int'(s_init[n]);
        i = 0;
        j = 0;
        for (int k = 0; k < int'(ML); k++) begin
            i = (i + 1) % 256;
            j = (j + model_s[i]) % 256;
            t = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
            model_f[k] = model_s[(model_s[i] + model_s[j]) % 256] ^ int'(rom_mem[k]);
        end
    endtask

    task automatic load_mem();
        @(negedge CLOCK_50) load = 1'b1;
        @(negedge CLOCK_50) load = 1'b0;
    endtask

    task automatic set_identity();
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    endtask

    task automatic start_run();
        @(negedge CLOCK_50) start = 1'b1;
        @(posedge CLOCK_50);
        #1 e0 = cyc;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && (cyc - e0) < 2000) begin
            @(posedge CLOCK_50);
            #1;
        end
        check("done_latency", 32'(cyc - e0), 32'(13 * ML));
    endtask

    task automatic finish_run();
        repeat (3) @(posedge CLOCK_50);
        #1 check("done_hold", 32'(done), 32'd1);
        @(negedge CLOCK_50) start = 1'b0;
        @(posedge CLOCK_50);
        #1 check("done_drop", 32'(done), 32'd0);
    endtask

    task automatic compare_all(input string tag);
        int bad_s, bad_gap;
        ref_prga();
        check({tag, "_ram_wr_count"}, 32'(ram_cnt), 32'(ML));
        for (int k = 0; k < int'(ML); k++)
            check($sformatf("%s_ram[%0d]", tag, k), 32'(ram_mem[k]), 32'(model_f[k]));
        bad_s = 0;
        for (int n = 0; n < 256; n++) if (int'(smem[n]) != model_s[n]) bad_s++;
        check({tag, "_s_final_mismatches"}, 32'(bad_s), 32'd0);
        bad_gap = 0;
        for (int n = 1; n < int'(ML) && n < 64; n++)
            if (ram_cyc[n] - ram_cyc[n-1] != 13) bad_gap++;
        check({tag, "_ram_wr_spacing"}, 32'(bad_gap), 32'd0);
    endtask

    task automatic wait_ram_cnt(input int target);
        int t = 0;
        while (ram_cnt < target && t < 1000) begin
            @(posedge CLOCK_50);
            #1 t++;
        end
        check("wait_ram_cnt", 32'(ram_cnt >= target), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"},        32'(done),            32'd0);
        check({tag, "_s_wren"},      32'(bus.s_wren),      32'd0);
        check({tag, "_ram_wren"},    32'(bus.ram_wren),    32'd0);
        check({tag, "_s_address"},   32'(bus.s_address),   32'd0);
        check({tag, "_s_data"},      32'(bus.s_data),      32'd0);
        check({tag, "_rom_address"}, 32'(bus.rom_address), 32'd0);
        check({tag, "_ram_address"}, 32'(bus.ram_address), 32'd0);
        check({tag, "_ram_data"},    32'(bus.ram_data),    32'd0);
    endtask

    logic [7:0] rc4_key [3] = '{8'h4B, 8'h65, 8'h79};
    logic [7:0] rc4_ct  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] rc4_pt  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

    initial begin
        int j, t, r;

        // reset state
        #1 check_outputs_zero("reset");

        // identity S, all-zero ROM
        set_identity();
        for (int k = 0; k < int'(ML); k++) rom_mem[k] = 8'h00;
        load_mem();
        @(negedge CLOCK_50) reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        #1 check("idle_done", 32'(done), 32'd0);
        start_run();
        wait_ram_cnt(3);
        check("id_ram0", 32'(ram_mem[0]), 32'h02);
        check("id_ram1", 32'(ram_mem[1]), 32'h05);
        check("id_ram2", 32'(ram_mem[2]), 32'h07);
        check("id_s2", 32'(smem[2]), 32'd3);
        check("id_s3", 32'(smem[3]), 32'd5);
        check("id_s5", 32'(smem[5]), 32'd2);
        check("ieqj_wr0_addr", 32'(sw_a[0]), 32'd1);
        check("ieqj_wr0_data", 32'(sw_d[0]), 32'd1);
        check("ieqj_wr1_addr", 32'(sw_a[1]), 32'd1);
        check("ieqj_wr1_data", 32'(sw_d[1]), 32'd1);
        check("ieqj_s1", 32'(smem[1]), 32'd1);
        wait_done();
        compare_all("identity");
        finish_run();

        // identity S, ROM[0]=0xFF
        set_identity();
        rom_mem[0] = 8'hFF;
        load_mem();
        start_run();
        wait_done();
        check("ff_ram0", 32'(ram_mem[0]), 32'hFD);
        compare_all("rom_ff");
        finish_run();

        // random permutations and random ciphertext; run 1 toggles start mid-run
        for (int run = 0; run < 3; run++) begin
            set_identity();
            for (int n = 255; n > 0; n--) begin
                r = int'($urandom_range(n, 0));
                t = int'(s_init[n]);
                s_init[n] = s_init[r];
                s_init[r] = 8'(t);
            end
            for (int k = 0; k < int'(ML); k++) rom_mem[k] = 8'($urandom);
            load_mem();
            start_run();
            if (run == 1) begin
                repeat (40) @(posedge CLOCK_50);
                @(negedge CLOCK_50) start = 1'b0;
                repeat (3) @(negedge CLOCK_50);
                start = 1'b1;
            end
            wait_done();
            compare_all($sformatf("rand%0d", run));
            finish_run();
        end

        // known RC4 vector: key "Key", plaintext "Plaintext"
        set_identity();
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(s_init[n]) + int'(rc4_key[n % 3])) % 256;
            t = int'(s_init[n]);
            s_init[n] = s_init[j];
            s_init[j] = 8'(t);
        end
        for (int k = 0; k < int'(ML); k++) rom_mem[k] = 8'h00;
        for (int k = 0; k < 9; k++) rom_mem[k] = rc4_ct[k];
        load_mem();
        start_run();
        wait_done();
        for (int k = 0; k < 9; k++)
            check($sformatf("rc4_pt[%0d]", k), 32'(ram_mem[k]), 32'(rc4_pt[k]));
        compare_all("rc4");
        finish_run();

        // reset in the middle of byte 10, then restart from a fresh image
        for (int k = 0; k < int'(ML); k++) rom_mem[k] = 8'($urandom);
        load_mem();
        start_run();
        wait_ram_cnt(10);
        repeat (5) @(posedge CLOCK_50);
        #3 reset = 1'b0;
        #1 check_outputs_zero("midrun_reset");
        start = 1'b0;
        load_mem();
        @(negedge CLOCK_50) reset = 1'b1;
        start_run();
        wait_done();
        check("restart_first_addr", 32'(ram_alog[0]), 32'd0);
        compare_all("restart");
        finish_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
